instr_fetch_stage: RTL and testbench
====================================

// Module: instr_fetch_stage
// PURPOSE
//  PC generation, instruction-memory fetch handshake and IF/ID pipeline register.
//  Sits directly upstream of control_unit: id_opcode/id_funct3/id_funct7 drive its inputs.
//  Absorbs downstream stalls with a one-entry skid register and handles redirects (branch/jump flush).
// PARAMETERS
//  XLEN      32            datapath / address width
//  RESET_PC  32'h0000_0000 PC loaded on reset
//  NOP_INSTR 32'h0000_0013 instruction presented while id_valid=0 (ADDI x0,x0,0)
// PORTS
//  clk            in   1     single clock; all state updates on posedge
//  rst            in   1     synchronous, active-high reset
//  imem_req       out  1     fetch request; imem_addr stable while high
//  imem_addr      out  XLEN  word-aligned fetch address (=pc)
//  imem_ack       in   1     one-cycle response strobe; imem_rdata valid same cycle
//  imem_rdata     in   32    fetched instruction
//  stall          in   1     downstream hazard: hold IF/ID contents
//  redirect_valid in   1     flush + load new PC (taken branch/jump)
//  redirect_pc    in   XLEN  redirect target
//  id_valid       out  1     IF/ID holds a real instruction
//  id_pc          out  XLEN  PC of id_instr
//  id_instr       out  32    IF/ID instruction
//  id_opcode      out  7     id_instr[6:0]
//  id_funct3      out  3     id_instr[14:12]
//  id_funct7      out  7     id_instr[31:25]
//  id_rd/id_rs1/id_rs2 out 5 id_instr[11:7]/[19:15]/[24:20]
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, imem_req=0, id_valid=0, id_instr=NOP_INSTR, id_pc=0, skid empty.
//  FSM states: IDLE, REQ, HOLD, FLUSH. imem_req=1 only in REQ.
//   IDLE : unconditional -> REQ next cycle.
//   REQ  : ack & !stall -> IF/ID<= {1,pc,rdata}; pc<=pc+4; stay REQ (back-to-back, 1 instr/cycle max).
//          ack & stall  -> skid<=rdata; IF/ID unchanged; -> HOLD.
//          !ack & !stall-> id_valid<=0, id_instr<=NOP_INSTR (bubble); stay REQ.
//          !ack & stall -> IF/ID unchanged; stay REQ.
//   HOLD : stall -> stay. !stall -> IF/ID<= {1,pc,skid}; pc<=pc+4; -> REQ.
//   FLUSH: one cycle with imem_req=0 (aborts any pending fetch); -> REQ.
//  Fetch latency: instruction visible on id_* the cycle after imem_ack.
//  Redirect (any state): highest priority over stall and ack. pc<=redirect_pc with bits[1:0] forced 0;
//   id_valid<=0, id_instr<=NOP_INSTR; skid discarded; same-cycle ack data dropped; -> FLUSH.
//  Memory contract: dropping imem_req aborts an un-acked request; ack never arrives with req low.
//  pc+4 wraps modulo 2^XLEN (32'hFFFF_FFFC -> 0). imem_addr changes only on ack/skid-drain/redirect.
//  Field outputs are pure slices of id_instr (NOP fields when id_valid=0).
//  rst asserted mid-fetch: reset values next cycle; in-flight ack ignored.
// CONFIGURATION
//  FETCH_STALL_CNT_EN defined: adds output fetch_stall_cnt [31:0]; reset 0; +1 each cycle
//   state==HOLD or (state==REQ & !imem_ack); saturates at 32'hFFFF_FFFF; cleared only by rst.
//  Not defined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1. rst 2 cycles, ack every REQ cycle, rdata 0x00000033,0x40000033 -> id_pc 0,4; id_opcode 0x33; id_funct7 0x00 then 0x20.
//  2. ack at 0x8 while stall=1 for 3 cycles -> state HOLD, imem_req=0, IF/ID unchanged; stall drop -> id_pc=0x8, next imem_addr=0xC.
//  3. redirect_valid with redirect_pc=0x103 coincident with ack -> ack data dropped, id_valid=0, next imem_addr=0x100 after 1-cycle FLUSH.
//  4. pc=0xFFFF_FFFC, ack -> id_pc=0xFFFF_FFFC, next imem_addr=0x0.
//  5. ack withheld 4 cycles, stall=0 -> id_valid=0, id_instr=0x13, imem_addr held; FETCH_STALL_CNT_EN: fetch_stall_cnt=4.
//  6. rst asserted in HOLD with skid full -> next cycle id_valid=0, imem_addr=RESET_PC, skid discarded.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: PC generation, imem request/ack handshake, one-entry skid and IF/ID register.
// Optional FETCH_STALL_CNT_EN adds a saturating fetch_stall_cnt output.
module instr_fetch_stage #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_opcode,
  output logic [2:0]      id_funct3,
  output logic [6:0]      id_funct7,
  output logic [4:0]      id_rd,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [1:0]      state_dbg
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     fetch_stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, FLUSH = 2'd3} state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc;
  logic [31:0]     skid;
  logic            capture_rdata, capture_skid, drain_skid, bubble;

  // Handshake: imem_req is held with a stable imem_addr until a one-cycle imem_ack
  // returns data; lowering imem_req abandons the request, and ack never comes with req low.
  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign state_dbg = state;

  always_comb begin
    state_next    = state;
    capture_rdata = 1'b0;
    capture_skid  = 1'b0;
    drain_skid    = 1'b0;
    bubble        = 1'b0;
    case (state)
      IDLE: state_next = REQ;
      REQ: begin
        if (imem_ack && !stall) begin
          capture_rdata = 1'b1;
        end else if (imem_ack && stall) begin
          capture_skid = 1'b1;
          state_next   = HOLD;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          drain_skid = 1'b1;
          state_next = REQ;
        end
      end
      FLUSH: state_next = REQ;
      default: state_next = IDLE;
    endcase
    // Redirect beats stall and ack: any same-cycle fetch result is discarded.
    if (redirect_valid) begin
      state_next    = FLUSH;
      capture_rdata = 1'b0;
      capture_skid  = 1'b0;
      drain_skid    = 1'b0;
      bubble        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      skid     <= '0;
      id_valid <= 1'b0;
      id_pc    <= '0;
      id_instr <= NOP_INSTR;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc       <= redirect_pc & ~XLEN'(3);
        skid     <= '0;
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end else if (capture_rdata) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_instr <= imem_rdata;
        pc       <= pc + XLEN'(4);
      end else if (capture_skid) begin
        skid <= imem_rdata;
      end else if (drain_skid) begin
        id_valid <= 1'b1;
        id_pc    <= pc;
        id_instr <= skid;
        pc       <= pc + XLEN'(4);
        skid     <= '0;
      end else if (bubble) begin
        id_valid <= 1'b0;
        id_instr <= NOP_INSTR;
      end
    end
  end

  assign id_opcode = id_instr[6:0];
  assign id_rd     = id_instr[11:7];
  assign id_funct3 = id_instr[14:12];
  assign id_rs1    = id_instr[19:15];
  assign id_rs2    = id_instr[24:20];
  assign id_funct7 = id_instr[31:25];

`ifdef FETCH_STALL_CNT_EN
  // Counts cycles the fetch side is waiting: parked in HOLD or requesting without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_stall_cnt <= '0;
    end else if (((state == HOLD) || (state == REQ && !imem_ack)) && (fetch_stall_cnt != 32'hFFFF_FFFF)) begin
      fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed + short random bench for instr_fetch_stage with an expected-instruction queue.
module tb_instr_fetch_stage;

  localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_HOLD = 2'd2, S_FLUSH = 2'd3;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [1:0]  state_dbg;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] fetch_stall_cnt;
  logic [31:0] cnt_before;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];
  logic [31:0] pc_model;

  instr_fetch_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .state_dbg(state_dbg)
`ifdef FETCH_STALL_CNT_EN
    , .fetch_stall_cnt(fetch_stall_cnt)
`endif
  );

  // clock / reset driving
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: pop the oldest expected {pc, instr} and compare against IF/ID
  task automatic expect_id(input string tag);
    logic [63:0] e;
    check({tag, "_valid"}, 64'(id_valid), 64'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue: observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, 64'(id_pc), 64'(e[63:32]));
      check({tag, "_instr"}, 64'(id_instr), 64'(e[31:0]));
    end
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic stl);
    imem_ack   = ack;
    imem_rdata = data;
    stall      = stl;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    check("rst_state", 64'(state_dbg), 64'(S_IDLE));
    check("rst_req", 64'(imem_req), 64'd0);
    check("rst_valid", 64'(id_valid), 64'd0);
    check("rst_instr", 64'(id_instr), 64'(NOP));
    check("rst_pc", 64'(id_pc), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);

    // 1: back-to-back fetches
    rst = 1'b0;
    tick();
    check("t1_req", 64'(imem_req), 64'd1);
    drive(1'b1, 32'h0000_0033, 1'b0); exp_q.push_back({32'h0, 32'h0000_0033});
    tick();
    expect_id("t1a");
    check("t1a_opcode", 64'(id_opcode), 64'h33);
    check("t1a_funct7", 64'(id_funct7), 64'h00);
    check("t1a_addr", 64'(imem_addr), 64'h4);
    drive(1'b1, 32'h4000_0033, 1'b0); exp_q.push_back({32'h4, 32'h4000_0033});
    tick();
    expect_id("t1b");
    check("t1b_funct7", 64'(id_funct7), 64'h20);

    // 2: ack under stall goes to the skid, drains when stall drops
    drive(1'b1, 32'h40C5_8533, 1'b1);
    tick();
    drive(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("t2_state", 64'(state_dbg), 64'(S_HOLD));
      check("t2_req", 64'(imem_req), 64'd0);
      check("t2_id_pc", 64'(id_pc), 64'h4);
      check("t2_id_instr", 64'(id_instr), 64'h4000_0033);
      check("t2_addr", 64'(imem_addr), 64'h8);
      if (i < 2) tick();
    end
    stall = 1'b0; exp_q.push_back({32'h8, 32'h40C5_8533});
    tick();
    expect_id("t2");
    check("t2_addr_next", 64'(imem_addr), 64'hC);
    check("t2_state_req", 64'(state_dbg), 64'(S_REQ));
    check("t2_rd", 64'(id_rd), 64'd10);
    check("t2_rs1", 64'(id_rs1), 64'd11);
    check("t2_rs2", 64'(id_rs2), 64'd12);
    check("t2_funct3", 64'(id_funct3), 64'd0);

    // 3: redirect coincident with ack
    drive(1'b1, 32'hDEAD_BEEF, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0; drive(1'b0, 32'h0, 1'b0);
    check("t3_valid", 64'(id_valid), 64'd0);
    check("t3_instr", 64'(id_instr), 64'(NOP));
    check("t3_state", 64'(state_dbg), 64'(S_FLUSH));
    check("t3_req", 64'(imem_req), 64'd0);
    tick();
    check("t3_req_after", 64'(imem_req), 64'd1);
    check("t3_addr", 64'(imem_addr), 64'h100);

    // 4: PC wrap
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("t4_addr", 64'(imem_addr), 64'hFFFF_FFFC);
    drive(1'b1, 32'h0010_0073, 1'b0); exp_q.push_back({32'hFFFF_FFFC, 32'h0010_0073});
    tick();
    expect_id("t4");
    check("t4_wrap", 64'(imem_addr), 64'h0);

    // 5: ack withheld for 4 cycles
    drive(1'b0, 32'h0, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    cnt_before = fetch_stall_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t5_valid", 64'(id_valid), 64'd0);
      check("t5_instr", 64'(id_instr), 64'(NOP));
      check("t5_addr", 64'(imem_addr), 64'h0);
    end
`ifdef FETCH_STALL_CNT_EN
    check("t5_cnt", 64'(fetch_stall_cnt - cnt_before), 64'd4);
`endif

    // 6: reset while holding a skid entry
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    tick();
    drive(1'b1, 32'h1111_1111, 1'b1);
    tick();
    check("t6_hold", 64'(state_dbg), 64'(S_HOLD));
    rst = 1'b1; drive(1'b0, 32'h0, 1'b0);
    tick();
    check("t6_valid", 64'(id_valid), 64'd0);
    check("t6_addr", 64'(imem_addr), 64'h0);
    check("t6_state", 64'(state_dbg), 64'(S_IDLE));
    rst = 1'b0;
    tick();
    check("t6_state_req", 64'(state_dbg), 64'(S_REQ));
    check("t6_no_drain", 64'(id_valid), 64'd0);
    drive(1'b1, 32'h0020_8133, 1'b0); exp_q.push_back({32'h0, 32'h0020_8133});
    tick();
    expect_id("t6");

    // random ack pattern, no stall
    pc_model = 32'h4;
    for (int i = 0; i < 20; i++) begin
      logic a;
      logic [31:0] d;
      a = 1'($urandom_range(0, 1));
      d = $urandom;
      drive(a, d, 1'b0);
      if (a) begin
        exp_q.push_back({pc_model, d});
        pc_model = pc_model + 32'd4;
      end
      tick();
      if (a) expect_id("rnd");
      else check("rnd_bubble", 64'(id_valid), 64'd0);
      check("rnd_addr", 64'(imem_addr), 64'(pc_model));
    end
    drive(1'b0, 32'h0, 1'b0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
